// File: rtl/cpu_forwarding_core.sv
// Five-stage pipelined core (fetch/decode/execute/memory/writeback) with full
// operand forwarding, load-use interlock, branch flush, bus-wait freeze and HALT.
module cpu_forwarding_core #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int NUM_REGS   = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   output logic [ADDR_WIDTH-1:0] o_pc,
   input  logic [31:0]           i_instruction,
   output logic                  o_mem_req,
   output logic                  o_rw,
   output logic [ADDR_WIDTH-1:0] o_address,
   output logic [DATA_WIDTH-1:0] o_data,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_mem_ready,
   output logic                  o_halted,
   output logic                  o_debug_stall,
   output logic                  o_debug_flush
);

   localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LW   = 8'h01;
   localparam logic [7:0] OP_SW   = 8'h02;
   localparam logic [7:0] OP_ADD  = 8'h03;
   localparam logic [7:0] OP_SUB  = 8'h04;
   localparam logic [7:0] OP_ADDI = 8'h05;
   localparam logic [7:0] OP_BEQ  = 8'h06;
   localparam logic [7:0] OP_HALT = 8'hFF;

   function automatic logic [7:0] norm_op(input logic [7:0] op);
      case (op)
         OP_LW, OP_SW, OP_ADD, OP_SUB, OP_ADDI, OP_BEQ, OP_HALT: return op;
         default:                                               return OP_NOP;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [7:0] op);
      return (op == OP_LW) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
   endfunction

   function automatic logic is_alu(input logic [7:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI);
   endfunction

   // pipeline state
   logic [ADDR_WIDTH-1:0] pc, id_pc, ex_pc;
   logic [31:0]           ir;
   logic [7:0]            ex_op, mem_op, wb_op;
   logic [RW-1:0]         ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
   logic [DATA_WIDTH-1:0] ex_a, ex_b, mem_val, mem_store, wb_val;
   logic [15:0]           ex_imm;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // decode
   logic [7:0]            id_op;
   logic [RW-1:0]         id_rd, id_rs1, id_rs2;
   logic [DATA_WIDTH-1:0] id_a, id_b;
   logic                  use_rs1, use_rs2, load_use, halt_stop;

   // execute / memory / control
   logic [DATA_WIDTH-1:0] fwd_a, fwd_b, alu_out, mem_result;
   logic [ADDR_WIDTH-1:0] br_off, br_target;
   logic                  branch_taken, mem_access, freeze, flush, stall, wb_wr;

   assign id_op  = norm_op(ir[31:24]);
   assign id_rd  = ir[20 +: RW];
   assign id_rs1 = ir[16 +: RW];
   assign id_rs2 = ir[12 +: RW];
   assign wb_wr  = writes_rd(wb_op);

   // register read with write-through from the instruction retiring this cycle
   always_comb begin
      id_a = regs[id_rs1];
      id_b = regs[id_rs2];
      if (wb_wr && (wb_rd == id_rs1)) id_a = wb_val;
      if (wb_wr && (wb_rd == id_rs2)) id_b = wb_val;
   end

   assign use_rs1 = (id_op == OP_LW) || (id_op == OP_SW) || (id_op == OP_ADD) ||
                    (id_op == OP_SUB) || (id_op == OP_ADDI) || (id_op == OP_BEQ);
   assign use_rs2 = (id_op == OP_SW) || (id_op == OP_ADD) || (id_op == OP_SUB) ||
                    (id_op == OP_BEQ);
   assign load_use = (ex_op == OP_LW) &&
                     ((use_rs1 && (id_rs1 == ex_rd)) || (use_rs2 && (id_rs2 == ex_rd)));
   // once HALT is decoded, fetch stays stopped until it is flushed or reset
   assign halt_stop = (id_op == OP_HALT) || (ex_op == OP_HALT) ||
                      (mem_op == OP_HALT) || (wb_op == OP_HALT);

   // later assignment wins, so the memory-stage ALU result has top priority
   always_comb begin
      fwd_a = ex_a;
      fwd_b = ex_b;
      if (wb_wr && (wb_rd == ex_rs1)) fwd_a = wb_val;
      if (wb_wr && (wb_rd == ex_rs2)) fwd_b = wb_val;
      if (is_alu(mem_op) && (mem_rd == ex_rs1)) fwd_a = mem_val;
      if (is_alu(mem_op) && (mem_rd == ex_rs2)) fwd_b = mem_val;
   end

   always_comb begin
      alu_out = '0;
      case (ex_op)
         OP_ADD:                alu_out = fwd_a + fwd_b;
         OP_SUB:                alu_out = fwd_a - fwd_b;
         OP_ADDI, OP_LW, OP_SW: alu_out = fwd_a + DATA_WIDTH'(ex_imm);
         default:               alu_out = '0;
      endcase
   end

   assign branch_taken = (ex_op == OP_BEQ) && (fwd_a == fwd_b);
   assign br_off       = ADDR_WIDTH'($signed(ex_imm));
   assign br_target    = ex_pc + (br_off << 2);

   assign mem_access = (mem_op == OP_LW) || (mem_op == OP_SW);
   assign mem_result = (mem_op == OP_LW) ? i_data : mem_val;
   assign freeze     = (mem_access && !i_mem_ready) || (wb_op == OP_HALT);
   assign flush      = !freeze && branch_taken;
   assign stall      = !freeze && !branch_taken && load_use;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc        <= '0;
         id_pc     <= '0;
         ir        <= '0;
         ex_op     <= OP_NOP;
         ex_rd     <= '0;
         ex_rs1    <= '0;
         ex_rs2    <= '0;
         ex_a      <= '0;
         ex_b      <= '0;
         ex_imm    <= '0;
         ex_pc     <= '0;
         mem_op    <= OP_NOP;
         mem_rd    <= '0;
         mem_val   <= '0;
         mem_store <= '0;
         wb_op     <= OP_NOP;
         wb_rd     <= '0;
         wb_val    <= '0;
      end else if (!freeze) begin
         if (flush)                        pc <= br_target;
         else if (!stall && !halt_stop)    pc <= pc + ADDR_WIDTH'(4);

         if (flush || (!stall && halt_stop)) begin
            ir <= '0;
         end else if (!stall) begin
            ir    <= i_instruction;
            id_pc <= pc;
         end

         if (flush || stall) begin
            ex_op <= OP_NOP;
         end else begin
            ex_op  <= id_op;
            ex_rd  <= id_rd;
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
            ex_a   <= id_a;
            ex_b   <= id_b;
            ex_imm <= ir[15:0];
            ex_pc  <= id_pc;
         end

         mem_op    <= ex_op;
         mem_rd    <= ex_rd;
         mem_val   <= alu_out;
         mem_store <= fwd_b;

         wb_op  <= mem_op;
         wb_rd  <= mem_rd;
         wb_val <= mem_result;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_wr) begin
         regs[wb_rd] <= wb_val;
      end
   end

   assign o_pc          = pc;
   assign o_mem_req     = mem_access;
   assign o_rw          = (mem_op == OP_SW);
   assign o_address     = mem_access ? mem_val[ADDR_WIDTH-1:0] : '0;
   assign o_data        = (mem_op == OP_SW) ? mem_store : '0;
   assign o_halted      = (wb_op == OP_HALT);
   assign o_debug_stall = stall;
   assign o_debug_flush = flush;

endmodule
